// File: rtl/dpd_cfg_pkg.sv
// Shared definitions for the DPD actuator configuration master and its neighbours.
// Holds the FSM state encoding, the actuator readback latency and default bus widths.
// Widths here are the defaults the actuator wrappers are built with.
package dpd_cfg_pkg;

    // Default widths shared with the actuator wrappers
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 10;
    localparam int DEF_LID_WIDTH  = 6;

    // Cycles from an actuator read request (enc=1, wec=0) to its validc pulse
    localparam int ACT_RD_LATENCY = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WR     = 3'd1,
        ST_WR_END = 3'd2,
        ST_RD     = 3'd3,
        ST_DRAIN  = 3'd4
    } state_t;

endpackage

// File: rtl/dpd_lut_cfg_master.sv
// Purpose : command-driven burst write / readback master for the DPD actuator LUT config port.
// Latency : write beat reaches the port 1 cycle after acceptance; readback beat 1 cycle after validc.
// Backpr. : cmd_ready only in IDLE, wdata_ready only in WR; rdata has no backpressure.
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   cmd_valid/cmd_ready, cmd_rnw,    command handshake and fields (len = beats - 1)
//   cmd_lut_id, cmd_addr, cmd_len
//   wdata_valid/wdata_ready, wdata   write-data stream
//   rdata_valid, rdata, rdata_last,  readback stream; rdata_err marks a timeout abort beat
//   rdata_err
//   busy                             high whenever the FSM is not idle
//   enc, wec, lutIdc, addrc, dinc    actuator config port drive (lutIdc is one-hot)
//   doutc, validc                    actuator readback data / valid
module dpd_lut_cfg_master
    import dpd_cfg_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int LID_WIDTH  = DEF_LID_WIDTH,
    parameter int RD_TIMEOUT = 15
) (
    input  logic                        clk,
    input  logic                        rst_n,

    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_rnw,
    input  logic [LID_WIDTH-1:0]        cmd_lut_id,
    input  logic [ADDR_WIDTH-1:0]       cmd_addr,
    input  logic [ADDR_WIDTH-1:0]       cmd_len,

    input  logic                        wdata_valid,
    output logic                        wdata_ready,
    input  logic [DATA_WIDTH-1:0]       wdata,

    output logic                        rdata_valid,
    output logic [DATA_WIDTH-1:0]       rdata,
    output logic                        rdata_last,
    output logic                        rdata_err,

    output logic                        busy,

    output logic                        enc,
    output logic                        wec,
    output logic [(2**LID_WIDTH)-1:0]   lutIdc,
    output logic [ADDR_WIDTH-1:0]       addrc,
    output logic [DATA_WIDTH-1:0]       dinc,
    input  logic [DATA_WIDTH-1:0]       doutc,
    input  logic                        validc
);

    localparam int ID_MAX = 2**LID_WIDTH;
    localparam int TMR_W  = (RD_TIMEOUT < 1) ? 1 : $clog2(RD_TIMEOUT + 1);

    state_t                 state;
    logic [ADDR_WIDTH-1:0]  len;      // latched beats-minus-1
    logic [ADDR_WIDTH-1:0]  addr;     // next address to put on the port
    logic [ADDR_WIDTH-1:0]  cnt;      // beats written / reads issued beyond the first
    logic [ADDR_WIDTH-1:0]  ret_cnt;  // read returns seen so far
    logic [TMR_W-1:0]       timer;    // idle cycles in DRAIN since the last validc

    // Handshake readiness and busy are pure decodes of the state register
    assign cmd_ready   = (state == ST_IDLE);
    assign wdata_ready = (state == ST_WR);
    assign busy        = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            len         <= '0;
            addr        <= '0;
            cnt         <= '0;
            ret_cnt     <= '0;
            timer       <= '0;
            enc         <= 1'b0;
            wec         <= 1'b0;
            lutIdc      <= '0;
            addrc       <= '0;
            dinc        <= '0;
            rdata_valid <= 1'b0;
            rdata       <= '0;
            rdata_last  <= 1'b0;
            rdata_err   <= 1'b0;
        end else begin
            // Readback flags are single-cycle pulses
            rdata_valid <= 1'b0;
            rdata_last  <= 1'b0;
            rdata_err   <= 1'b0;

            case (state)
                ST_IDLE: begin
                    enc <= 1'b0;
                    wec <= 1'b0;
                    if (cmd_valid) begin
                        len     <= cmd_len;
                        lutIdc  <= ID_MAX'(1) << cmd_lut_id;
                        cnt     <= '0;
                        ret_cnt <= '0;
                        timer   <= '0;
                        if (cmd_rnw) begin
                            // First read is issued straight from the accept edge
                            enc   <= 1'b1;
                            addrc <= cmd_addr;
                            addr  <= cmd_addr + ADDR_WIDTH'(1);
                            state <= ST_RD;
                        end else begin
                            addr  <= cmd_addr;
                            state <= ST_WR;
                        end
                    end
                end

                ST_WR: begin
                    // enc follows the beat handshake, so gaps show as enc=0
                    enc <= wdata_valid;
                    wec <= wdata_valid;
                    if (wdata_valid) begin
                        addrc <= addr;
                        dinc  <= wdata;
                        addr  <= addr + ADDR_WIDTH'(1);
                        if (cnt == len) begin
                            state <= ST_WR_END;
                        end else begin
                            cnt <= cnt + ADDR_WIDTH'(1);
                        end
                    end
                end

                ST_WR_END: begin
                    // Last beat is on the port this cycle; release everything after it
                    enc    <= 1'b0;
                    wec    <= 1'b0;
                    lutIdc <= '0;
                    state  <= ST_IDLE;
                end

                ST_RD, ST_DRAIN: begin
                    if (state == ST_RD) begin
                        if (cnt == len) begin
                            enc   <= 1'b0;
                            timer <= '0;
                            state <= ST_DRAIN;
                        end else begin
                            enc   <= 1'b1;
                            addrc <= addr;
                            addr  <= addr + ADDR_WIDTH'(1);
                            cnt   <= cnt + ADDR_WIDTH'(1);
                        end
                    end

                    // Returns are accepted while issuing as well as while draining;
                    // the final return overrides the issue logic above.
                    if (validc) begin
                        rdata_valid <= 1'b1;
                        rdata       <= doutc;
                        ret_cnt     <= ret_cnt + ADDR_WIDTH'(1);
                        timer       <= '0;
                        if (ret_cnt == len) begin
                            rdata_last <= 1'b1;
                            enc        <= 1'b0;
                            lutIdc     <= '0;
                            state      <= ST_IDLE;
                        end
                    end else if (state == ST_DRAIN) begin
                        if (timer == TMR_W'(RD_TIMEOUT)) begin
                            rdata_valid <= 1'b1;
                            rdata_last  <= 1'b1;
                            rdata_err   <= 1'b1;
                            rdata       <= '0;
                            lutIdc      <= '0;
                            state       <= ST_IDLE;
                        end else begin
                            timer <= timer + TMR_W'(1);
                        end
                    end
                end

                default: begin
                    enc    <= 1'b0;
                    wec    <= 1'b0;
                    lutIdc <= '0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
